// File: rtl/prbs16_pkg.sv
// Shared definitions for the 16-bit PRBS checker and the generator model that
// feeds it: polynomial x^16+x^14+x^13+x^11+1 tap positions, FSM state enum,
// and the next-bit helper function.
package prbs16_pkg;

  localparam int unsigned LFSR_W = 16;

  // History tap positions; history[0] holds the most recent bit.
  localparam int unsigned TAP_A = 10;
  localparam int unsigned TAP_B = 12;
  localparam int unsigned TAP_C = 13;
  localparam int unsigned TAP_D = 15;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Next bit of the sequence: b_t = b_{t-11}^b_{t-13}^b_{t-14}^b_{t-16}.
  function automatic logic prbs_pred(input logic [LFSR_W-1:0] h);
    return h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D];
  endfunction

endpackage

// File: rtl/prbs16_checker_if.sv
// Serial-input / status-output bundle of the PRBS checker.
//   in_bit, in_valid, clr_err : driven by the link side (master)
//   locked, err_pulse, err_count : driven by the checker (slave)
interface prbs16_checker_if #(
  parameter int unsigned ERR_W = 8
) ();

  logic             in_bit;
  logic             in_valid;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_bit, in_valid, clr_err,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  in_bit, in_valid, clr_err,
    output locked, err_pulse, err_count
  );

endinterface

// File: rtl/prbs16_predictor.sv
// PRBS16 predictor: 16-bit history shift register plus combinational
// next-bit prediction.
//   clk, rst_n   : clock, async active-low reset (clears history)
//   shift_en     : shift one bit into history[0] this cycle
//   use_pred     : shift source select, 1 = predicted bit, 0 = in_bit
//   in_bit       : received bit
//   pred_c       : predicted value of the bit arriving now
//   next_nz_c    : post-shift history would be non-zero
module prbs16_predictor
  import prbs16_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic use_pred,
  input  logic in_bit,
  output logic pred_c,
  output logic next_nz_c
);

  logic [LFSR_W-1:0] history_q;
  logic [LFSR_W-1:0] history_d;
  logic              shift_bit;

  assign pred_c    = prbs_pred(history_q);
  assign shift_bit = use_pred ? pred_c : in_bit;
  assign history_d = {history_q[LFSR_W-2:0], shift_bit};
  assign next_nz_c = |history_d;

  // History register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_q <= '0;
    end else if (shift_en) begin
      history_q <= history_d;
    end
  end

endmodule

// File: rtl/prbs16_checker.sv
// Self-synchronising PRBS16 checker. Searches for LOCK_COUNT consecutive
// correct predictions, then flywheels its predictor and counts bit errors,
// dropping lock when LOSS_THRESH errors fall within a LOSS_WINDOW-bit window.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of prbs16_checker_if (serial in, status out)
module prbs16_checker
  import prbs16_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = 32,
  parameter int unsigned LOSS_WINDOW = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 8
) (
  input logic             clk,
  input logic             rst_n,
  prbs16_checker_if.slave bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned FILL_W = 5;

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   win_err_q, win_err_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic               shift_en_c;
  logic               use_pred_c;
  logic               pred_c;
  logic               next_nz_c;
  logic               mismatch_c;
  logic [SUM_W-1:0]   win_err_sum_c;

  prbs16_predictor u_pred (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en_c),
    .use_pred  (use_pred_c),
    .in_bit    (bus.in_bit),
    .pred_c    (pred_c),
    .next_nz_c (next_nz_c)
  );

  assign mismatch_c    = bus.in_bit ^ pred_c;
  assign win_err_sum_c = {1'b0, win_err_q} + SUM_W'(mismatch_c);

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    shift_en_c  = 1'b0;
    use_pred_c  = (state_q == LOCKED);

    if (bus.in_valid) begin
      shift_en_c = 1'b1;
      case (state_q)
        SEARCH: begin
          if (fill_q != FILL_W'(LFSR_W)) begin
            fill_d = fill_q + FILL_W'(1);
          end else if (mismatch_c) begin
            match_d = '0;
          end else begin
            // Holds at LOCK_COUNT on an all-zero stream instead of wrapping.
            if (match_q != CNT_W'(LOCK_COUNT)) begin
              match_d = match_q + CNT_W'(1);
            end
            if ((match_d == CNT_W'(LOCK_COUNT)) && next_nz_c) begin
              state_d = LOCKED;
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (mismatch_c) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
          end
          if (win_err_sum_c >= SUM_W'(LOSS_THRESH)) begin
            state_d   = SEARCH;
            fill_d    = '0;
            match_d   = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q == CNT_W'(LOSS_WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
            win_err_d = CNT_W'(win_err_sum_c);
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    // Clear wins over a same-cycle increment.
    if (bus.clr_err) begin
      err_count_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule
